crack_result_tx: RTL and testbench
==================================

// Module: crack_result_tx
// PURPOSE
//  Return path from the FPGA cracker to the host. Keeps a delay line of issued guesses so each
//  guess lines up with the MD5 pipeline's hit flag. On a hit, latches the matching plaintext and
//  sends it to the host as a serial 8N1 frame. Sits beside MD5Pipeline in the cracker top level.
//  Inputs: GuessGenerator guess/done and the top-level hit comparator.
// PARAMETERS
//  PIPE_LATENCY  65   clocks from guess entering MD5Pipeline to its hit being valid (>=1)
//  CLK_DIV       434  clocks per UART bit (50 MHz / 115200); must be >=2
//  GUESS_BYTES   16   plaintext bytes per frame; guess width = 8*GUESS_BYTES
// PORTS
//  clk      in   1    system clock; all logic on rising edge
//  reset    in   1    asynchronous, active-low reset
//  guess    in   128  guess issued to MD5Pipeline this cycle
//  hit      in   1    hash match for guess issued PIPE_LATENCY cycles earlier
//  done     in   1    generator exhausted keyspace (level)
//  tx       out  1    UART serial out, idle high
//  busy     out  1    frame in progress
//  found    out  1    sticky: at least one hit captured since reset
//  dropped  out  8    hits lost while busy, saturating
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, busy=0, found=0, dropped=0.
//   Delay-line valid bits, FSM state, byte/bit/baud counters cleared.
//   Delay-line data is don't-care.
//  Delay line:
//   - PIPE_LATENCY-stage shift of {valid, guess}; valid=1 shifted in every cycle out of reset.
//   - hit only counts when the tail valid bit is 1.
//   - Hits during the first PIPE_LATENCY cycles after reset are ignored.
//  Capture:
//   - Qualified hit with busy=0: latch tail guess, set found, busy=1 on the next clock.
//   - Qualified hit with busy=1: dropped += 1, saturating at 255 (never wraps); frame unaffected.
//  Frame: 0x48 ('H'), then GUESS_BYTES bytes MSB first (guess[127:120] first), then 0x0A.
//  FSM: IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE).
//   - START: tx=0 for CLK_DIV clocks.
//   - DATA: 8 bits, LSB first, CLK_DIV clocks each.
//   - STOP: tx=1 for CLK_DIV clocks.
//  Timing:
//   - First start bit begins the clock after capture.
//   - Frame length = (GUESS_BYTES+2)*10*CLK_DIV clocks.
//   - busy falls the same clock the FSM returns to IDLE; no gap is required before the next frame.
//  Reset mid-frame: tx returns high immediately (async); the partial frame is abandoned and never resumed.
//  guess/done are not sampled by the FSM after capture; a frame's contents are stable once latched.
// CONFIGURATION
//  REPORT_DONE_EN defined:
//   - On rising edge of done, set pending_done.
//   - When IDLE with pending_done and no qualified hit, send 2-byte frame 0x44 ('D'), 0x0A, then clear pending_done.
//   - Sent once per done rising edge.
//   - Qualified hit and pending_done together in IDLE: hit frame first, done frame afterwards.
//   - done rising while busy: done frame queued behind the current frame.
//  REPORT_DONE_EN undefined: done is ignored entirely; only hit frames are ever sent.
// TESTING (CLK_DIV=4, PIPE_LATENCY=3 unless noted)
//  1. Reset, guess="abc" left-aligned, hit pulses 3 clocks after issue:
//     tx emits 0x48 0x61 0x62 0x63 0x00x13 0x0A; busy for 720 clocks; found=1.
//  2. hit asserted during the first 3 clocks after reset release -> no frame, found=0, dropped=0.
//  3. Second hit mid-frame, then 300 more hits while busy:
//     first frame intact; dropped=1 after the second hit, saturates at 0xFF.
//  4. Assert reset during byte 5 of a frame:
//     tx=1 and busy=0 within the reset assertion; after release, idle with no resumed output.
//  5. REPORT_DONE_EN, hit and done rise on the same cycle:
//     hit frame (18 bytes), then 'D' 0x0A; done held high produces no second 'D' frame.
//  6. Bit timing: CLK_DIV=434 -> each tx bit stays stable exactly 434 clocks; LSB sent first (0x48 -> 0,0,0,1,0,0,1,0).

Source files
------------

// File: rtl/crack_result_tx.sv
// crack_result_tx: result return path of the MD5 cracker.
// A delay line of issued guesses is kept aligned with the MD5 pipeline hit flag.
// A qualified hit latches the matching plaintext and sends it as an 8N1 UART frame:
// 'H', the GUESS_BYTES plaintext bytes (MSB first), then '\n'.
// Optional feature, compile-time macro REPORT_DONE_EN: each rising edge of done queues
// a 2-byte 'D' '\n' frame. This frame is sent when the transmitter is idle and no hit
// takes priority.
module crack_result_tx #(
   parameter int unsigned PIPE_LATENCY = 65,
   parameter int unsigned CLK_DIV      = 434,
   parameter int unsigned GUESS_BYTES  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [8*GUESS_BYTES-1:0]   guess,
   input  logic                       hit,
   input  logic                       done,
   output logic                       tx,
   output logic                       busy,
   output logic                       found,
   output logic [7:0]                 dropped
);

   localparam int unsigned GW     = 8 * GUESS_BYTES;
   localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BYTE_W = $clog2(GUESS_BYTES + 2);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] HIT_LAST  = BYTE_W'(GUESS_BYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // delay line
   logic [PIPE_LATENCY-1:0] dl_valid_q;
   logic [GW-1:0]           dl_data_q [PIPE_LATENCY];
   logic                    qual_hit;
   logic [GW-1:0]           tail_data;

   // transmitter state
   state_e                  state_q;
   logic                    tx_q;
   logic                    busy_q;
   logic                    found_q;
   logic [7:0]              dropped_q;
   logic [BAUD_W-1:0]       baud_q;
   logic [2:0]              bit_q;
   logic [BYTE_W-1:0]       byte_q;
   logic [7:0]              shift_q;
   logic [GW-1:0]           frame_q;
   logic                    done_frame_q;

   // next-byte selection
   logic [BYTE_W-1:0]       next_idx_d;
   logic [BYTE_W-1:0]       last_idx_d;
   logic [BYTE_W+2:0]       shamt_d;
   logic [GW-1:0]           shifted_d;
   logic [7:0]              next_byte_d;

`ifdef REPORT_DONE_EN
   logic                    done_q;
   logic                    pending_q;
`else
   logic                    unused_done;
   assign unused_done = done;
`endif

   // Validity shift: a 1 enters every cycle out of reset; the tail qualifies hit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dl_valid_q <= '0;
      end else begin
         dl_valid_q[0] <= 1'b1;
         for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
         end
      end
   end

   // Guess data shift; the contents do not matter until the matching valid bit arrives.
   always_ff @(posedge clk) begin
      dl_data_q[0] <= guess;
      for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
         dl_data_q[i] <= dl_data_q[i-1];
      end
   end

   assign qual_hit  = hit & dl_valid_q[PIPE_LATENCY-1];
   assign tail_data = dl_data_q[PIPE_LATENCY-1];

   // Byte that follows the current one in the frame being sent.
   always_comb begin
      next_idx_d  = byte_q + 1'b1;
      last_idx_d  = done_frame_q ? BYTE_W'(1) : HIT_LAST;
      shamt_d     = {next_idx_d - 1'b1, 3'b000};
      shifted_d   = frame_q << shamt_d;
      next_byte_d = shifted_d[GW-1 -: 8];
      if (done_frame_q || (next_idx_d == HIT_LAST)) begin
         next_byte_d = 8'h0A;
      end
   end

   // Capture, drop counter and UART framing FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
         dropped_q    <= '0;
         baud_q       <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         shift_q      <= '0;
         frame_q      <= '0;
         done_frame_q <= 1'b0;
`ifdef REPORT_DONE_EN
         done_q       <= 1'b0;
         pending_q    <= 1'b0;
`endif
      end else begin
         if (qual_hit && busy_q && (dropped_q != 8'hFF)) begin
            dropped_q <= dropped_q + 8'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (qual_hit) begin
                  frame_q      <= tail_data;
                  found_q      <= 1'b1;
                  done_frame_q <= 1'b0;
                  shift_q      <= 8'h48;
                  state_q      <= S_START;
                  tx_q         <= 1'b0;
                  busy_q       <= 1'b1;
                  baud_q       <= '0;
                  byte_q       <= '0;
               end
`ifdef REPORT_DONE_EN
               else if (pending_q) begin
                  pending_q    <= 1'b0;
                  done_frame_q <= 1'b1;
                  shift_q      <= 8'h44;
                  state_q      <= S_START;
                  tx_q         <= 1'b0;
                  busy_q       <= 1'b1;
                  baud_q       <= '0;
                  byte_q       <= '0;
               end
`endif
            end

            S_START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            S_DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[1];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            S_STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (byte_q == last_idx_d) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     byte_q  <= next_idx_d;
                     shift_q <= next_byte_d;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase

`ifdef REPORT_DONE_EN
         // Placed after the FSM so a new rising edge wins over the clear in IDLE.
         done_q <= done;
         if (done && !done_q) begin
            pending_q <= 1'b1;
         end
`endif
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign found   = found_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_crack_result_tx.sv
// Directed bench for crack_result_tx with CLK_DIV=4 and PIPE_LATENCY=3.
// A second instance uses CLK_DIV=434 to check exact bit timing.
module tb_crack_result_tx;

   logic         clk;
   logic         reset;
   logic [127:0] guess;
   logic         hit;
   logic         done;
   logic         tx;
   logic         busy;
   logic         found;
   logic [7:0]   dropped;

   logic         s_reset;
   logic [127:0] s_guess;
   logic         s_hit;
   logic         s_done;
   logic         s_tx;
   logic         s_busy;
   logic         s_found;
   logic [7:0]   s_dropped;

   int total = 0;
   int bad   = 0;
   int busy_cnt = 0;

   crack_result_tx #(.PIPE_LATENCY(3), .CLK_DIV(4), .GUESS_BYTES(16)) u_dut (
      .clk(clk), .reset(reset), .guess(guess), .hit(hit), .done(done),
      .tx(tx), .busy(busy), .found(found), .dropped(dropped)
   );

   crack_result_tx #(.PIPE_LATENCY(3), .CLK_DIV(434), .GUESS_BYTES(16)) u_slow (
      .clk(clk), .reset(s_reset), .guess(s_guess), .hit(s_hit), .done(s_done),
      .tx(s_tx), .busy(s_busy), .found(s_found), .dropped(s_dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [127:0] g0;
      logic [127:0] g1;
      int           hit_step;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for a start bit and samples all 40 clocks of the character.
   task automatic rx_byte(output logic [7:0] b, output bit ok);
      logic [39:0] smp;
      int n;
      ok = 1'b1;
      b  = '0;
      n  = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         ok = 1'b0;
         return;
      end
      for (int i = 0; i < 40; i++) begin
         smp[i] = tx;
         if (i < 39) @(negedge clk);
      end
      for (int j = 0; j < 10; j++) begin
         for (int k = 1; k < 4; k++) begin
            if (smp[4*j+k] !== smp[4*j]) ok = 1'b0;
         end
      end
      if (smp[0] !== 1'b0 || smp[36] !== 1'b1) ok = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = smp[4*(j+1)];
   endtask

   task automatic rx_hit_frame(input logic [127:0] g, input string name);
      logic [7:0] b;
      logic [7:0] e;
      bit ok;
      for (int k = 0; k < 18; k++) begin
         if (k == 0) e = 8'h48;
         else if (k == 17) e = 8'h0A;
         else e = g[127-8*(k-1) -: 8];
         rx_byte(b, ok);
         check($sformatf("%s byte%0d", name, k), {ok, b}, {1'b1, e});
         if (!ok) return;
      end
   endtask

   task automatic expect_idle(input int n, input string name);
      int errs = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      check(name, errs, 0);
   endtask

   // Issues g then hits it PIPE_LATENCY clocks later; capture happens at the last step.
   task automatic launch(input logic [127:0] g);
      guess = g;
      step();
      guess = ~g;
      step();
      step();
      hit = 1'b1;
      step();
      hit = 1'b0;
   endtask

   logic [9:0] exp_bits;

   initial begin
      logic [127:0] g3;
      logic [127:0] g4;

      vecs[0] = '{{24'h616263, 104'h0}, {128{1'b1}} ^ 128'h1, 3, {24'h616263, 104'h0}};
      vecs[1] = '{128'h00112233445566778899AABBCCDDEEFF, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 4,
                  128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0};
      vecs[2] = '{{128{1'b1}}, 128'h0, 3, {128{1'b1}}};
      vecs[3] = '{128'h80000000000000000000000000000001, {16{8'hA5}}, 3,
                  128'h80000000000000000000000000000001};
      g3 = 128'h7071727374757677_78797A7B7C7D7E7F;
      g4 = 128'hC0FFEE00_DEADBEEF_12345678_9ABCDEF0;
      exp_bits = {1'b1, 8'h48, 1'b0};

      reset   = 1'b0;
      guess   = '0;
      hit     = 1'b0;
      done    = 1'b0;
      s_reset = 1'b0;
      s_guess = '0;
      s_hit   = 1'b0;
      s_done  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset state", {tx, busy, found, dropped}, {1'b1, 1'b0, 1'b0, 8'h00});

      // hits during the first PIPE_LATENCY clocks after release are ignored
      @(posedge clk);
      #1 reset = 1'b1;
      hit = 1'b1;
      step();
      step();
      step();
      hit = 1'b0;
      expect_idle(60, "early hit no frame");
      check("early hit flags", {found, dropped}, {1'b0, 8'h00});

      // table-driven hit frames, back to back
      foreach (vecs[i]) begin
         step();
         busy_cnt = 0;
         guess = vecs[i].g0;
         for (int s = 1; s <= vecs[i].hit_step; s++) begin
            step();
            guess = (s == 1) ? vecs[i].g1 : ~vecs[i].g0;
         end
         hit = 1'b1;
         step();
         hit = 1'b0;
         rx_hit_frame(vecs[i].exp, $sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d busy clocks", i), busy_cnt, 720);
         check($sformatf("vec%0d flags", i), {busy, found, dropped}, {1'b0, 1'b1, 8'h00});
      end

`ifdef REPORT_DONE_EN
      // hit and done rising together: hit frame first, then a single 'D' frame
      begin
         logic [7:0] b;
         bit ok;
         step();
         guess = g3;
         step();
         step();
         step();
         hit  = 1'b1;
         done = 1'b1;
         step();
         hit = 1'b0;
         rx_hit_frame(g3, "hitdone");
         rx_byte(b, ok);
         check("done frame byte0", {ok, b}, {1'b1, 8'h44});
         rx_byte(b, ok);
         check("done frame byte1", {ok, b}, {1'b1, 8'h0A});
         expect_idle(200, "done held no repeat");
         done = 1'b0;
         step();
      end
`else
      step();
      done = 1'b1;
      expect_idle(100, "done ignored");
      done = 1'b0;
`endif

      // hits while busy: frame intact, drop counter saturates
      step();
      launch(g3);
      fork
         rx_hit_frame(g3, "dropframe");
         begin
            repeat (60) step();
            guess = ~g3;
            hit = 1'b1;
            step();
            hit = 1'b0;
            @(negedge clk);
            check("dropped after one", dropped, 8'd1);
            step();
            hit = 1'b1;
            repeat (300) begin
               step();
               guess = guess + 128'd1;
            end
            hit = 1'b0;
            @(negedge clk);
            check("dropped saturated", dropped, 8'hFF);
         end
      join
      @(negedge clk);
      check("after drop frame", {busy, found, dropped}, {1'b0, 1'b1, 8'hFF});

      // reset in the middle of byte 5
      step();
      launch(g4);
      repeat (175) @(posedge clk);
      #3 reset = 1'b0;
      #1 check("async reset mid frame", {tx, busy, found, dropped}, {1'b1, 1'b0, 1'b0, 8'h00});
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      expect_idle(300, "no resumed frame");
      check("after reset flags", {found, dropped}, {1'b0, 8'h00});

      // exact bit timing at CLK_DIV=434, first character 0x48
      step();
      s_reset = 1'b1;
      step();
      step();
      step();
      s_hit = 1'b1;
      step();
      s_hit = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (s_tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
         end
         check("slow start seen", (n < 2000), 1'b1);
         if (n < 2000) begin
            for (int j = 0; j < 10; j++) begin
               int errs = 0;
               for (int k = 0; k < 434; k++) begin
                  if (s_tx !== exp_bits[j]) errs++;
                  @(negedge clk);
               end
               check($sformatf("slow bit%0d stable", j), errs, 0);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
